// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude select for one Booth digit: 0, 1*y or 2*y
  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_ONE  = 2'd1;
  localparam logic [1:0] SEL_TWO  = 2'd2;

  localparam logic NEG_ON  = 1'b1;
  localparam logic NEG_OFF = 1'b0;

endpackage

// File: rtl/booth_digit_sel.sv
// Modified Booth recoding of one 3-bit multiplier window into a multiple of y.
module booth_digit_sel
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2:0]       i_win,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH:0]   o_mag,
  output logic             o_neg
);

  logic [1:0] w_sel;

  always_comb begin
    w_sel = SEL_ZERO;
    o_neg = NEG_OFF;
    unique case (i_win)
      3'b000, 3'b111: begin w_sel = SEL_ZERO; o_neg = NEG_OFF; end
      3'b001, 3'b010: begin w_sel = SEL_ONE;  o_neg = NEG_OFF; end
      3'b011:         begin w_sel = SEL_TWO;  o_neg = NEG_OFF; end
      3'b100:         begin w_sel = SEL_TWO;  o_neg = NEG_ON;  end
      default:        begin w_sel = SEL_ONE;  o_neg = NEG_ON;  end
    endcase
  end

  // WIDTH+1 bits hold both sign-extended y and 2*y without overflow
  always_comb begin
    o_mag = '0;
    case (w_sel)
      SEL_ONE: o_mag = {i_y[WIDTH-1], i_y};
      SEL_TWO: o_mag = {i_y, 1'b0};
      default: o_mag = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier: one Booth digit of x retired per cycle.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = $clog2(DIGITS);

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_p;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [WIDTH:0]     w_xext;
  logic [2:0]         w_win;
  logic [WIDTH:0]     w_mag;
  logic               w_neg;
  logic [2*WIDTH-1:0] w_mag_ext;
  logic [2*WIDTH-1:0] w_term;
  logic [2*WIDTH-1:0] w_acc_next;

  // x[-1] is the appended zero below the LSB
  assign w_xext = {r_x, 1'b0};
  assign w_win  = w_xext[{r_count, 1'b0} +: 3];

  booth_digit_sel #(.WIDTH(WIDTH)) u_sel (
    .i_win (w_win),
    .i_y   (r_y),
    .o_mag (w_mag),
    .o_neg (w_neg)
  );

  // Negate after sign extension so -2*(-2^(WIDTH-1)) stays exact
  assign w_mag_ext  = {{(WIDTH-1){w_mag[WIDTH]}}, w_mag};
  assign w_term     = w_neg ? (~w_mag_ext + 1'b1) : w_mag_ext;
  assign w_acc_next = r_acc + (w_term << {r_count, 1'b0});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_acc       <= '0;
      r_p         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x        <= x;
            r_y        <= y;
            r_acc      <= '0;
            r_count    <= '0;
            r_state    <= BUSY;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        BUSY: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(DIGITS - 1)) begin
            r_p         <= w_acc_next;
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign p         = r_p;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomized checks of booth_mult_seq against hand-computed products.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] p;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_mult_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from IDLE; holds out_ready low for 'stalls' cycles in DONE
  task automatic run_job(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int stalls);
    int n;
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    x = a;
    y = b;
    tick();
    in_valid = 1'b0;
    x = $urandom();
    y = $urandom();
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_p"}, p, exp);
    for (int i = 0; i < stalls; i++) begin
      tick();
      chk({tag, "_hold_ov"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_hold_p"}, p, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_ov"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
    $display("job %s: x=0x%04h y=0x%04h p=0x%08h want=0x%08h", tag, a, b, p, exp);
  endtask

  initial begin
    logic signed [15:0] ra;
    logic signed [15:0] rb;
    logic signed [31:0] re;
    int n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_p", p, 32'd0);

    // Latency: accept at T, out_valid exactly at T+9, IDLE at T+10
    in_valid = 1'b1; x = 16'd3; y = 16'd5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_rdy_T1", {31'd0, in_ready}, 32'd0);
    for (int i = 2; i <= 8; i++) tick();
    chk("lat_ov_T8", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_ov_T9", {31'd0, out_valid}, 32'd1);
    chk("lat_p", p, 32'h0000000F);
    tick();
    chk("lat_rdy_T10", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
    $display("job latency: x=3 y=5 p=0x%08h", p);

    run_job("minmin", 16'h8000, 16'h8000, 32'h40000000, 0);
    run_job("maxmin", 16'h7FFF, 16'h8000, 32'hC0008000, 0);
    run_job("neg1x1", 16'hFFFF, 16'h0001, 32'hFFFFFFFF, 0);
    run_job("backp",  16'h1234, 16'h0010, 32'h00012340, 5);
    run_job("zero",   16'h0000, 16'h1234, 32'h00000000, 0);
    run_job("maxmax", 16'h7FFF, 16'h7FFF, 32'h3FFF0001, 1);
    run_job("minmax", 16'h8000, 16'h7FFF, 32'hC0008000, 0);
    run_job("m1m1",   16'hFFFF, 16'hFFFF, 32'h00000001, 0);
    run_job("3xm5",   16'h0003, 16'hFFFB, 32'hFFFFFFF1, 2);
    run_job("sq256",  16'h0100, 16'h0100, 32'h00010000, 0);

    // in_valid held through BUSY/DONE must not disturb the running job
    in_valid = 1'b1; x = 16'd2; y = 16'd3;
    tick();
    x = 16'd7; y = 16'd7;
    for (int i = 0; i < 8; i++) begin
      chk("ign_rdy", {31'd0, in_ready}, 32'd0);
      tick();
    end
    chk("ign_ov", {31'd0, out_valid}, 32'd1);
    chk("ign_p", p, 32'h00000006);
    out_ready = 1'b1;
    tick();
    chk("ign_back_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("ign_second_acc", {31'd0, busy}, 32'd1);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk("ign_second_p", p, 32'h00000031);
    tick();
    out_ready = 1'b0;
    $display("job ignore: second p=0x00000031 expected, in_ready=%0d", in_ready);

    // Reset while BUSY at count=4
    in_valid = 1'b1; x = 16'h00FF; y = 16'h00FF;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_rdy", {31'd0, in_ready}, 32'd1);
    chk("mrst_ov", {31'd0, out_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_p", p, 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) n++;
    end
    chk("mrst_stale", n, 32'd0);
    $display("job midreset: stale out_valid count=%0d", n);
    run_job("postrst", 16'hFFFE, 16'hFFFE, 32'h00000004, 0);

    // Randomized pairs against a signed reference product
    for (int k = 0; k < 300; k++) begin
      ra = 16'($urandom());
      rb = 16'($urandom());
      re = ra * rb;
      run_job("rand", ra, rb, re, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
